watchdog_windowed: RTL
======================

Name: watchdog_windowed

Overview:
- Parametrised successor to the fixed 4-bit watchdog: W-bit up-counter with a run-time programmable timeout limit.
- Adds an early-warning flag, an optional window mode (a kick that arrives too early is a fault), a sticky early-kick error, and a stretched system-reset request pulse.
- Sits between the software-kicked restart strobe and the chip reset controller.

Parameters:
- W, 8, counter, limit and window width in bits (W >= 2).
- WARN_MARGIN, 4, warn asserts when count >= limit_q - WARN_MARGIN (saturating at 0).
- RST_PULSE_CYCLES, 4, length of rst_req in cycles (>= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  watchdog run enable; low forces IDLE and clears the counter.
- restart  in  1  kick strobe, sampled each edge.
- limit  in  W  timeout limit, latched into limit_q.
- win_open  in  W  earliest legal kick count, latched into win_q.
- window_en  in  1  window mode enable, latched into wen_q.
- count  out  W  current counter value.
- warn  out  1  early-warning flag.
- timeout  out  1  high while in EXPIRED.
- early_err  out  1  sticky flag: a kick arrived before the window opened.
- rst_req  out  1  system reset request pulse.

Behaviour:
- States: IDLE, COUNT, EXPIRED.
- All outputs are decoded from registers; there are no combinational input-to-output paths.
- Priority, highest first: rst, then enable=0, then restart, then the limit compare.

- rst:
  - state=IDLE, count=0, limit_q=0, win_q=0, wen_q=0, early_err=0, pulse counter=0.
  - All outputs 0 in the following cycle.
  - Applies from any state, including mid-pulse; an rst_req pulse in progress is cut off.
- enable=0: state=IDLE, count=0, early_err=0, in any state. An rst_req pulse already in progress still completes.
- IDLE with enable=1:
  - Next state COUNT, count=0.
  - Latch limit_q, win_q and wen_q.
  - If wen_q would be 1 and win_open > limit, win_q = limit (clamp).
- COUNT, restart=1:
  - Window violation when wen_q=1 and count < win_q.
  - Violation: early_err<=1 and state goes to EXPIRED (immediate fault).
  - Otherwise (valid kick): count<=0 and limit_q/win_q/wen_q are re-latched.
  - A valid kick wins over a limit match on the same edge.
- COUNT, restart=0:
  - If count==limit_q, go to EXPIRED and count holds.
  - Otherwise count<=count+1.
  - Timeout therefore asserts limit_q+1 edges after entering COUNT; limit=0 expires on the first edge.
  - No wrap-around: the compare always fires at or before 2^W-1.
- EXPIRED:
  - timeout=1 and count holds, saturated.
  - restart=1: go to COUNT with count=0 and re-latch; timeout drops the next cycle. No window check applies in EXPIRED.
- warn = (state==COUNT) && (count >= sat0(limit_q - WARN_MARGIN)). warn is 0 in IDLE and EXPIRED.
- rst_req:
  - Asserts in the cycle timeout first rises, on each entry into EXPIRED.
  - Stays high exactly RST_PULSE_CYCLES cycles, unaffected by restart.
  - A re-entry during a pulse restarts the pulse count.
- early_err is cleared only by rst or enable=0.
- limit/win_open changes take effect only at a latch point: the IDLE-to-COUNT transition or a valid kick.

Decomposition:
- Package watchdog_pkg:
  - wdt_state_t enum (IDLE, COUNT, EXPIRED).
  - Default width constants.
  - sat0 subtract function.
- Sub-module wdt_pulse_gen (parameter RST_PULSE_CYCLES):
  - Inputs: clk, rst, trigger.
  - Output: pulse.
  - Down-counter sized $clog2(RST_PULSE_CYCLES+1).

Test Plan:
- W=8, limit=5, enable 0->1, no restart -> count 0..5 over edges 0..5; timeout=1 and rst_req high 4 cycles from edge 6; warn=1 from count=1.
- limit=10, window_en=0, restart at count=7 -> count=0 next cycle; no timeout within 11 cycles; repeat kicks keep timeout=0 indefinitely.
- window_en=1, win_open=6, limit=10, restart at count=3 -> early_err=1, timeout=1 next cycle, rst_req pulse; kick at count=6 -> accepted, count=0, early_err stays 0.
- Restart on the same edge as count==limit -> count=0, timeout never asserts; restart while in EXPIRED -> timeout=0 next cycle, rst_req still finishes 4 cycles.
- limit=0 -> timeout on first edge after enable; win_open=20 > limit=10 -> clamped; kick at 10 accepted, kick at 9 flags early_err.
- rst and enable=0 asserted mid-COUNT and mid-EXPIRED -> all outputs 0 next cycle; enable=0 with early_err=1 clears it; rst during rst_req truncates the pulse.

Source files
------------

// File: rtl/watchdog_pkg.sv
// Shared types, default sizing and helpers for the windowed watchdog.
// The FSM encoding is fixed so that waveforms stay readable across revisions.
package watchdog_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } wdt_state_t;

  localparam int          WDT_W_DEF         = 8;
  localparam int unsigned WDT_WARN_DEF      = 4;
  localparam int          WDT_RST_PULSE_DEF = 4;

  // Subtract that bottoms out at zero instead of wrapping.
  function automatic int unsigned sat0(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : 0;
  endfunction

endpackage

// File: rtl/wdt_pulse_gen.sv
// Fixed-length pulse stretcher: a trigger (re)loads a down-counter and the
// pulse is high while the counter is non-zero.
module wdt_pulse_gen #(
  parameter int RST_PULSE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic pulse
);

  localparam int            CW   = $clog2(RST_PULSE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(RST_PULSE_CYCLES);

  logic [CW-1:0] remain;

  always_ff @(posedge clk) begin
    if (rst) begin
      remain <= '0;
    end else if (trigger) begin
      remain <= LOAD;
    end else if (remain != '0) begin
      remain <= remain - CW'(1);
    end
  end

  assign pulse = (remain != '0);

endmodule

// File: rtl/watchdog_windowed.sv
// Windowed watchdog: programmable-limit up-counter with early warning,
// early-kick fault detection and a stretched reset request.
//
// state   | meaning
// IDLE    | disabled, counter cleared, config not yet latched
// COUNT   | running; a valid kick restarts the count and re-latches config
// EXPIRED | timed out or early kick seen; count saturated, waits for a kick
module watchdog_windowed
  import watchdog_pkg::*;
#(
  parameter int          W                = WDT_W_DEF,
  parameter int unsigned WARN_MARGIN      = WDT_WARN_DEF,
  parameter int          RST_PULSE_CYCLES = WDT_RST_PULSE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         restart,
  input  logic [W-1:0] limit,
  input  logic [W-1:0] win_open,
  input  logic         window_en,
  output logic [W-1:0] count,
  output logic         warn,
  output logic         timeout,
  output logic         early_err,
  output logic         rst_req
);

  wdt_state_t   state, state_nx;
  logic [W-1:0] count_nx;
  logic [W-1:0] limit_q, win_q;
  logic         wen_q;
  logic         relatch, err_set, early_kick, enter_exp;
  logic [W-1:0] warn_thr;
  logic [W-1:0] win_clamped;

  assign early_kick  = wen_q && (count < win_q);
  // A window that opens after the limit could never be met, so pin it to the limit.
  assign win_clamped = (window_en && (win_open > limit)) ? limit : win_open;

  always_comb begin
    state_nx = state;
    count_nx = count;
    relatch  = 1'b0;
    err_set  = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      count_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = COUNT;
          count_nx = '0;
          relatch  = 1'b1;
        end
        COUNT: begin
          if (restart) begin
            if (early_kick) begin
              err_set  = 1'b1;
              state_nx = EXPIRED;
            end else begin
              count_nx = '0;
              relatch  = 1'b1;
            end
          end else if (count == limit_q) begin
            state_nx = EXPIRED;
          end else begin
            count_nx = count + W'(1);
          end
        end
        EXPIRED: begin
          if (restart) begin
            state_nx = COUNT;
            count_nx = '0;
            relatch  = 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          count_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      limit_q   <= '0;
      win_q     <= '0;
      wen_q     <= 1'b0;
      early_err <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (relatch) begin
        limit_q <= limit;
        win_q   <= win_clamped;
        wen_q   <= window_en;
      end
      if (!enable) begin
        early_err <= 1'b0;
      end else if (err_set) begin
        early_err <= 1'b1;
      end
    end
  end

  // Fires on every entry into EXPIRED so a re-entry restarts the pulse.
  assign enter_exp = (state_nx == EXPIRED) && (state != EXPIRED);

  wdt_pulse_gen #(
    .RST_PULSE_CYCLES(RST_PULSE_CYCLES)
  ) u_pulse (
    .clk    (clk),
    .rst    (rst),
    .trigger(enter_exp),
    .pulse  (rst_req)
  );

  assign warn_thr = W'(sat0(32'(limit_q), WARN_MARGIN));
  assign warn     = (state == COUNT) && (count >= warn_thr);
  assign timeout  = (state == EXPIRED);

endmodule
